uart_cmd_decoder: RTL and testbench

- Command interpreter between the board UART and the port register file in s6base_top.
- Parses the serial host protocol and issues 32-bit port writes and reads:
  - write: command byte {4'b0010, port} followed by 4 data bytes, MSB first;
  - read: command byte {4'b0011, port}; the block returns 4 bytes, MSB first.
- Consumes UART receive bytes; drives the UART transmit handshake.

---
 rtl/uart_cmd_pkg.sv | 23 ++
 rtl/uart_tx_seq.sv | 61 ++++++
 rtl/uart_cmd_decoder.sv | 127 ++++++++++++
 tb/tb_uart_cmd_decoder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART host command decoder: command nibbles, frame length, FSM states.
package uart_cmd_pkg;

  localparam logic [3:0] CMD_WRITE  = 4'h2;
  localparam logic [3:0] CMD_READ   = 4'h3;
  localparam int         WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_COMMIT,
    ST_RD_REQ,
    ST_RD_LATCH,
    ST_TX
  } cmd_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_ACK
  } tx_state_t;

endpackage

// File: rtl/uart_tx_seq.sv
// Serialises a captured 32-bit word MSB first over the UART transmit handshake (txready/txen).
module uart_tx_seq
  import uart_cmd_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] word,
  input  logic        txready,
  output logic        txen,
  output logic [7:0]  txdata,
  output logic        done
);

  // state   | meaning
  // TX_IDLE | waiting for start, word not yet captured
  // TX_SEND | waiting for txready high to launch the next byte
  // TX_ACK  | waiting for txready low, the UART's acceptance of the byte

  tx_state_t   state;
  logic [31:0] tx_sr;
  logic [1:0]  idx;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= TX_IDLE;
      tx_sr  <= '0;
      idx    <= '0;
      txen   <= 1'b0;
      txdata <= '0;
      done   <= 1'b0;
    end else begin
      txen <= 1'b0;
      done <= 1'b0;
      case (state)
        TX_IDLE: if (start) begin
          tx_sr <= word;
          idx   <= '0;
          state <= TX_SEND;
        end
        TX_SEND: if (txready) begin
          txen   <= 1'b1;
          txdata <= tx_sr[31:24];
          state  <= TX_ACK;
        end
        TX_ACK: if (!txready) begin
          tx_sr <= {tx_sr[23:0], 8'h00};
          idx   <= idx + 1'b1;
          if (idx == 2'(WORD_BYTES - 1)) begin
            state <= TX_IDLE;
            done  <= 1'b1;
          end else begin
            state <= TX_SEND;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Host command interpreter: UART bytes in, 32-bit port writes/reads out, read replies back over UART.
// Optional inter-byte write timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int PORT_W         = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rxready,
  input  logic [7:0]        rxdata,
  input  logic              txready,
  output logic              txen,
  output logic [7:0]        txdata,
  output logic              wr_en,
  output logic [PORT_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [PORT_W-1:0] rd_addr,
  output logic              rd_req,
  input  logic [31:0]       rd_data,
  output logic              cmd_err,
  output logic              busy
);

  // state        | meaning
  // ST_IDLE      | accepting a command byte
  // ST_WR_DATA   | collecting the 4 write data bytes
  // ST_WR_COMMIT | transferring the assembled word to wr_data / wr_en
  // ST_RD_REQ    | rd_req high, port register file responding
  // ST_RD_LATCH  | rd_data valid, handed to the serialiser
  // ST_TX        | serialiser sending the 4 reply bytes

  cmd_state_t        state;
  logic [31:0]       sr;
  logic [1:0]        byte_cnt;
  logic [PORT_W-1:0] wr_addr_pend;
  logic              tx_start;
  logic              tx_done;
  logic              rx_discard;
  logic              to_expired;

  assign busy       = (state != ST_IDLE);
  assign tx_start   = (state == ST_RD_LATCH);
  assign rx_discard = rxready && (state != ST_IDLE) && (state != ST_WR_DATA);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clock) begin
    if (!reset_n || state != ST_WR_DATA || rxready) to_cnt <= '0;
    else if (!to_expired)                          to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_expired = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      sr           <= '0;
      byte_cnt     <= '0;
      wr_addr_pend <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      rd_addr      <= '0;
      rd_req       <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      rd_req  <= 1'b0;
      cmd_err <= rx_discard;
      case (state)
        ST_IDLE: if (rxready) begin
          if (rxdata[7:4] == CMD_WRITE) begin
            wr_addr_pend <= rxdata[PORT_W-1:0];
            byte_cnt     <= '0;
            state        <= ST_WR_DATA;
          end else if (rxdata[7:4] == CMD_READ) begin
            rd_addr <= rxdata[PORT_W-1:0];
            rd_req  <= 1'b1;
            state   <= ST_RD_REQ;
          end else begin
            cmd_err <= 1'b1;
          end
        end
        ST_WR_DATA: begin
          // a byte arriving on the expiry cycle still counts, so rxready wins
          if (rxready) begin
            sr       <= {sr[23:0], rxdata};
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'(WORD_BYTES - 1)) state <= ST_WR_COMMIT;
          end else if (to_expired) begin
            state   <= ST_IDLE;
            cmd_err <= 1'b1;
          end
        end
        ST_WR_COMMIT: begin
          wr_en   <= 1'b1;
          wr_data <= sr;
          wr_addr <= wr_addr_pend;
          state   <= ST_IDLE;
        end
        ST_RD_REQ:   state <= ST_RD_LATCH;
        ST_RD_LATCH: state <= ST_TX;
        ST_TX:       if (tx_done) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_seq u_tx_seq (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (tx_start),
    .word    (rd_data),
    .txready (txready),
    .txen    (txen),
    .txdata  (txdata),
    .done    (tx_done)
  );

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed protocol cases plus randomized frames vs a byte-level model.
module tb_uart_cmd_decoder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rxready = 1'b0;
  logic [7:0]  rxdata = 8'h00;
  logic        txready = 1'b1;
  logic [31:0] rd_data = 32'h0;
  logic        txen, wr_en, rd_req, cmd_err, busy;
  logic [7:0]  txdata;
  logic [3:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(50), .PORT_W(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rxready (rxready),
    .rxdata  (rxdata),
    .txready (txready),
    .txen    (txen),
    .txdata  (txdata),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_req  (rd_req),
    .rd_data (rd_data),
    .cmd_err (cmd_err),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // observed behaviour
  int          cyc = 0;
  int          last_data_cyc = 0;
  int          n_err = 0;
  int          txen_bad = 0;
  int          rd_hold = 0;
  int          tx_busy = 0;
  logic        mark_last = 1'b0;
  logic        tx_took = 1'b0;
  logic [35:0] wr_obs[$];
  int          lat_obs[$];
  logic [3:0]  rd_obs[$];
  logic [7:0]  tx_obs[$];

  // reference model expectations
  logic [31:0] port_mem[16];
  logic [35:0] wr_exp[$];
  logic [3:0]  rd_exp[$];
  logic [7:0]  tx_exp[$];
  int          err_exp = 0;

  always @(negedge clock) begin
    cyc++;
    if (rxready && mark_last) last_data_cyc = cyc;
    if (wr_en) begin
      wr_obs.push_back({wr_addr, wr_data});
      lat_obs.push_back(cyc - last_data_cyc);
    end
    // port file answers the cycle after rd_req, then rd_data wanders
    if (rd_req) begin
      rd_obs.push_back(rd_addr);
      rd_data = port_mem[rd_addr];
      rd_hold = 1;
    end else if (rd_hold > 0) begin
      rd_hold = 0;
    end else begin
      rd_data = $urandom;
    end
    tx_took = txen;
    if (txen) begin
      tx_obs.push_back(txdata);
      if (!txready) txen_bad++;
    end
    if (cmd_err) n_err++;
  end

  // UART transmitter: drops txready after accepting a byte, busy for a random time
  always @(posedge clock) begin
    #1;
    if (tx_took) begin
      txready = 1'b0;
      tx_busy = $urandom_range(0, 4);
    end else if (!txready) begin
      if (tx_busy == 0) txready = 1'b1;
      else tx_busy--;
    end
  end

  task automatic drive_rx(input logic v, input logic [7:0] b, input logic last);
    @(posedge clock);
    #1;
    rxready   = v;
    rxdata    = b;
    mark_last = last;
  endtask

  task automatic write_frame(input logic [3:0] port, input logic [31:0] data,
                             input int gap_max, input logic junk_after);
    drive_rx(1'b1, {4'h2, port}, 1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, gap_max)) drive_rx(1'b0, 8'h00, 1'b0);
      drive_rx(1'b1, data[31-8*i -: 8], i == 3);
    end
    if (junk_after) begin
      drive_rx(1'b1, {4'h2, 4'($urandom_range(0, 15))}, 1'b0);
      err_exp++;
    end
    drive_rx(1'b0, 8'h00, 1'b0);
    wr_exp.push_back({port, data});
  endtask

  task automatic read_frame(input logic [3:0] port, input logic inject, input logic [7:0] junk);
    logic [31:0] word;
    word = port_mem[port];
    drive_rx(1'b1, {4'h3, port}, 1'b0);
    rd_exp.push_back(port);
    for (int i = 0; i < 4; i++) tx_exp.push_back(word[31-8*i -: 8]);
    if (inject) begin
      repeat ($urandom_range(0, 4)) drive_rx(1'b0, 8'h00, 1'b0);
      drive_rx(1'b1, junk, 1'b0);
      err_exp++;
    end
    drive_rx(1'b0, 8'h00, 1'b0);
  endtask

  task automatic bad_cmd(input logic [7:0] b);
    drive_rx(1'b1, b, 1'b0);
    drive_rx(1'b0, 8'h00, 1'b0);
    err_exp++;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < 400) begin
      @(negedge clock);
      n++;
    end
    check_val({tag, ".idle"}, 64'(busy), 64'd0);
    repeat (3) @(negedge clock);
  endtask

  task automatic flush(input string tag);
    check_val({tag, ".n_wr"}, 64'(wr_obs.size()), 64'(wr_exp.size()));
    for (int i = 0; i < wr_exp.size() && i < wr_obs.size(); i++) begin
      check_val({tag, ".wr"}, 64'(wr_obs[i]), 64'(wr_exp[i]));
      check_val({tag, ".wr_lat"}, 64'(lat_obs[i]), 64'd2);
    end
    check_val({tag, ".n_rd"}, 64'(rd_obs.size()), 64'(rd_exp.size()));
    for (int i = 0; i < rd_exp.size() && i < rd_obs.size(); i++)
      check_val({tag, ".rd_addr"}, 64'(rd_obs[i]), 64'(rd_exp[i]));
    check_val({tag, ".n_tx"}, 64'(tx_obs.size()), 64'(tx_exp.size()));
    for (int i = 0; i < tx_exp.size() && i < tx_obs.size(); i++)
      check_val({tag, ".txdata"}, 64'(tx_obs[i]), 64'(tx_exp[i]));
    check_val({tag, ".cmd_err"}, 64'(n_err), 64'(err_exp));
    check_val({tag, ".txen_rdy"}, 64'(txen_bad), 64'd0);
    wr_obs.delete(); lat_obs.delete(); rd_obs.delete(); tx_obs.delete();
    wr_exp.delete(); rd_exp.delete(); tx_exp.delete();
    n_err = 0; err_exp = 0; txen_bad = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int nib;
    for (int i = 0; i < 16; i++) port_mem[i] = $urandom;
    port_mem[1] = 32'h0000_3800;

    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("rst.wr_en", 64'(wr_en), 64'd0);
    check_val("rst.busy", 64'(busy), 64'd0);
    check_val("rst.outs", 64'({txen, rd_req, cmd_err, txdata, wr_data, wr_addr, rd_addr}), 64'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    write_frame(4'd1, 32'h0000_0006, 0, 1'b0);
    wait_idle("wr_pos");
    flush("wr_pos");

    write_frame(4'd3, 32'hFFFF_FFB1, 2, 1'b0);
    wait_idle("wr_neg");
    check_val("wr_neg.hold", 64'({wr_addr, wr_data}), 64'({4'd3, 32'hFFFF_FFB1}));
    flush("wr_neg");

    read_frame(4'd1, 1'b0, 8'h00);
    wait_idle("rd");
    check_val("rd.busy_after", 64'(busy), 64'd0);
    flush("rd");

    bad_cmd(8'h45);
    wait_idle("bad");
    flush("bad");

    read_frame(4'd1, 1'b1, 8'h22);
    wait_idle("rd_inj");
    flush("rd_inj");

    drive_rx(1'b1, 8'h29, 1'b0);
    drive_rx(1'b1, 8'h00, 1'b0);
    drive_rx(1'b1, 8'h12, 1'b0);
    drive_rx(1'b0, 8'h00, 1'b0);
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    write_frame(4'd7, 32'h0, 0, 1'b0);
    wait_idle("rst_mid");
    flush("rst_mid");

    drive_rx(1'b1, 8'h26, 1'b0);
    drive_rx(1'b1, 8'hAA, 1'b0);
    drive_rx(1'b0, 8'h00, 1'b0);
    repeat (60) @(posedge clock);
    @(negedge clock);
`ifdef UART_CMD_TIMEOUT_EN
    check_val("timeout.busy", 64'(busy), 64'd0);
    err_exp++;
    write_frame(4'd6, 32'h00B6_0B4E, 0, 1'b0);
`else
    check_val("no_timeout.busy", 64'(busy), 64'd1);
    drive_rx(1'b1, 8'h00, 1'b0);
    drive_rx(1'b1, 8'hB6, 1'b0);
    drive_rx(1'b1, 8'h0B, 1'b1);
    drive_rx(1'b0, 8'h00, 1'b0);
    wr_exp.push_back({4'd6, 32'hAA00_B60B});
`endif
    wait_idle("timeout");
    flush("timeout");

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        write_frame(4'($urandom_range(0, 15)), $urandom, 3, ($urandom_range(0, 3) == 0));
      end else if (kind < 8) begin
        read_frame(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)));
      end else begin
        nib = $urandom_range(0, 13);
        if (nib >= 2) nib += 2;
        bad_cmd({4'(nib), 4'($urandom_range(0, 15))});
      end
      wait_idle("rnd");
      flush("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
